// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters and the one-hot serializer states
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_BAUD_COUNT = 868;

  typedef enum logic [4:0] {
    TX_IDLE  = 5'b00001,
    TX_START = 5'b00010,
    TX_DATA  = 5'b00100,
    TX_STOP  = 5'b01000,
    TX_DONE  = 5'b10000
  } tx_state_e;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-side bus of the transmitter: character, write strobe and FIFO status.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] DATA;
  logic                  WR;
  logic                  FULL;
  logic                  EMPTY;

  modport master (
    output DATA,
    output WR,
    input  FULL,
    input  EMPTY
  );

  modport slave (
    input  DATA,
    input  WR,
    output FULL,
    output EMPTY
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, registered FULL/EMPTY, head word read
// combinationally so the serializer can capture it on the pop edge.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_c_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  push_ok_c;
  logic                  pop_ok_c;

  // Writes while full and pops while empty are ignored outright.
  assign push_ok_c = push_i && !full_q;
  assign pop_ok_c  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8N1-style serializer (start, DATA_WIDTH bits
// LSB first, one stop bit) with a global enable that freezes a frame in place.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned BAUD_COUNT = UART_BAUD_COUNT,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic     CLK100MHZ,
  input  logic     RESET,
  input  logic     TXEN,
  uart_tx_if.slave wr_bus,
  output logic     TXD,
  output logic     BUSY,
  output logic     DONE
);

  localparam int unsigned CNT_W = cnt_width(BAUD_COUNT);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pop_c;
  logic                  cnt_last_c;
  logic [DATA_WIDTH-1:0] fifo_head_c;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK100MHZ),
    .rst_i       (RESET),
    .push_i      (wr_bus.WR),
    .wdata_i     (wr_bus.DATA),
    .pop_i       (pop_c),
    .rd_data_c_o (fifo_head_c),
    .full_o      (wr_bus.FULL),
    .empty_o     (wr_bus.EMPTY)
  );

  assign cnt_last_c = (cnt_q == CNT_W'(BAUD_COUNT - 1));

  // Next-state logic; every state except TX_DONE holds while TXEN is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_c   = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (TXEN && !wr_bus.EMPTY) begin
          pop_c   = 1'b1;
          shift_d = fifo_head_c;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (TXEN) begin
          if (cnt_last_c) begin
            cnt_d   = '0;
            state_d = TX_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (TXEN) begin
          if (cnt_last_c) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
              state_d = TX_STOP;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              shift_d = shift_q >> 1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (TXEN) begin
          if (cnt_last_c) begin
            cnt_d   = '0;
            state_d = TX_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // The frame is already complete here, so TX_DONE always retires to
      // keep DONE a single-cycle pulse; TX_IDLE then withholds the next pop.
      TX_DONE: begin
        state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Line level and status follow the next state so they register in step with it.
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE);
    done_d = (state_d == TX_DONE);
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_COUNT=16, FIFO_DEPTH=4: frame shape,
// bursts, overflow, full-boundary push/pop, TXEN pause and mid-frame reset.
module tb_uart_tx;

  localparam int DW        = 8;
  localparam int BC        = 16;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = (DW + 2) * BC + 1;

  logic clk;
  logic rst;
  logic txen;
  logic txd;
  logic busy;
  logic done;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(
    .DATA_WIDTH (DW),
    .BAUD_COUNT (BC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .TXEN      (txen),
    .wr_bus    (bus),
    .TXD       (txd),
    .BUSY      (busy),
    .DONE      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [7:0] ch);
    bus.WR   = 1'b1;
    bus.DATA = ch;
    tick();
    bus.WR   = 1'b0;
  endtask

  // Called in the pop cycle; returns in the DONE cycle. Expected line level is
  // derived from the number of enabled clock edges since the pop.
  task automatic run_frame(input logic [7:0] ch, input logic exp_empty,
                           input int pause_at, input int pause_len);
    int   k;
    int   prog;
    int   errs;
    int   done_k;
    int   done_cnt;
    int   slot;
    logic en_now;
    logic exp_txd;
    k = 0; prog = 0; errs = 0; done_k = -1; done_cnt = 0;
    check_eq("pop_idle_txd", 32'(txd), 32'd1);
    check_eq("pop_idle_busy", 32'(busy), 32'd0);
    check_eq("pop_has_data", 32'(bus.EMPTY), 32'd0);
    while (prog < FRAME_LEN && k < 1000) begin
      en_now = txen;
      tick();
      k++;
      if (en_now) prog++;
      if (k == 1) check_eq("post_pop_empty", 32'(bus.EMPTY), 32'(exp_empty));
      if (k == 3) bus.DATA = ~bus.DATA;
      slot = (prog - 1) / BC;
      if (prog >= FRAME_LEN)  exp_txd = 1'b1;
      else if (slot == 0)     exp_txd = 1'b0;
      else if (slot <= DW)    exp_txd = ch[slot-1];
      else                    exp_txd = 1'b1;
      if (txd !== exp_txd) errs++;
      if (busy !== 1'b1) errs++;
      if (done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (pause_len > 0 && k == pause_at)             txen = 1'b0;
      if (pause_len > 0 && k == pause_at + pause_len) txen = 1'b1;
    end
    check_eq("frame_txd_busy_errs", 32'(errs), 32'd0);
    check_eq("frame_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("frame_done_cycle", 32'(done_k), 32'(FRAME_LEN + pause_len));
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int lows;
    int dones;
    lows = 0; dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    check_eq({tag, "_txd_low_cycles"}, 32'(lows), 32'd0);
    check_eq({tag, "_done_pulses"}, 32'(dones), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0; txen = 1'b0; bus.WR = 1'b0; bus.DATA = '0;
    #2 rst = 1'b1;
    tick(); tick();
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_empty", 32'(bus.EMPTY), 32'd1);
    check_eq("rst_full", 32'(bus.FULL), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_txd", 32'(txd), 32'd1);
    check_eq("post_rst_empty", 32'(bus.EMPTY), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Single character 0xA5
    txen = 1'b1;
    write_one(8'hA5);
    run_frame(8'hA5, 1'b1, 0, 0);
    tick();
    check_eq("single_done_drop", 32'(done), 32'd0);
    check_eq("single_idle_busy", 32'(busy), 32'd0);
    check_eq("single_idle_txd", 32'(txd), 32'd1);

    // Burst of three, released together
    txen = 1'b0;
    write_one(8'h00);
    write_one(8'hFF);
    write_one(8'h55);
    check_eq("burst_full", 32'(bus.FULL), 32'd0);
    check_eq("burst_empty", 32'(bus.EMPTY), 32'd0);
    txen = 1'b1;
    run_frame(8'h00, 1'b0, 0, 0);
    tick();
    run_frame(8'hFF, 1'b0, 0, 0);
    tick();
    run_frame(8'h55, 1'b1, 0, 0);
    tick();
    check_eq("burst_idle_busy", 32'(busy), 32'd0);

    // Overflow: six writes into four entries with TXEN low
    txen = 1'b0;
    write_one(8'h11);
    write_one(8'h22);
    write_one(8'h33);
    check_eq("ovf_full_after3", 32'(bus.FULL), 32'd0);
    write_one(8'h44);
    check_eq("ovf_full_after4", 32'(bus.FULL), 32'd1);
    write_one(8'h55);
    write_one(8'h66);
    check_eq("ovf_full_after6", 32'(bus.FULL), 32'd1);
    check_eq("ovf_empty_after6", 32'(bus.EMPTY), 32'd0);
    txen = 1'b1;
    run_frame(8'h11, 1'b0, 0, 0);
    tick();
    run_frame(8'h22, 1'b0, 0, 0);
    tick();
    run_frame(8'h33, 1'b0, 0, 0);
    tick();
    run_frame(8'h44, 1'b1, 0, 0);
    idle_watch("ovf_no_fifth", 200);

    // Write while full in the same cycle as a pop
    txen = 1'b0;
    write_one(8'hA1);
    write_one(8'hA2);
    write_one(8'hA3);
    write_one(8'hA4);
    check_eq("fb_full", 32'(bus.FULL), 32'd1);
    txen = 1'b1;
    bus.WR = 1'b1;
    bus.DATA = 8'hEE;
    tick();
    bus.WR = 1'b0;
    check_eq("fb_full_after_pop", 32'(bus.FULL), 32'd0);
    check_eq("fb_empty_after_pop", 32'(bus.EMPTY), 32'd0);
    check_eq("fb_start_txd", 32'(txd), 32'd0);
    check_eq("fb_busy", 32'(busy), 32'd1);
    w = 0;
    while (done !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    check_eq("fb_first_done", 32'(done), 32'd1);
    check_eq("fb_first_len", 32'(w), 32'(FRAME_LEN - 1));
    tick();
    run_frame(8'hA2, 1'b0, 0, 0);
    tick();
    run_frame(8'hA3, 1'b0, 0, 0);
    tick();
    run_frame(8'hA4, 1'b1, 0, 0);
    idle_watch("fb_no_dropped", 60);

    // Pause of 50 cycles inside data bit 3
    txen = 1'b1;
    write_one(8'h08);
    run_frame(8'h08, 1'b1, 70, 50);
    tick();
    check_eq("pause_idle_busy", 32'(busy), 32'd0);

    // Reset during data bit 5, with a second character queued
    bus.WR = 1'b1;
    bus.DATA = 8'h5A;
    tick();
    bus.DATA = 8'h77;
    tick();
    bus.WR = 1'b0;
    check_eq("pushpop_empty", 32'(bus.EMPTY), 32'd0);
    repeat (99) tick();
    check_eq("rst_mid_pre_txd", 32'(txd), 32'd0);
    check_eq("rst_mid_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_txd", 32'(txd), 32'd1);
    check_eq("rst_mid_empty", 32'(bus.EMPTY), 32'd1);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle_watch("post_mid_rst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets bits per character.
REQ-002 Parameter BAUD_COUNT, default 868, sets clock cycles per bit (100 MHz / 115200 baud).
REQ-003 Parameter FIFO_DEPTH, default 16, sets transmit FIFO entries; it SHALL be a power of two, at least 2.
REQ-004 CLK100MHZ  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 TXEN  in  1  global enable; low SHALL freeze the serializer.
REQ-007 DATA  in  DATA_WIDTH  character to enqueue.
REQ-008 WR  in  1  write strobe; enqueues DATA when FULL is low.
REQ-009 FULL  out  1  FIFO holds FIFO_DEPTH entries.
REQ-010 EMPTY  out  1  FIFO holds zero entries.
REQ-011 TXD  out  1  serial line, idle high.
REQ-012 BUSY  out  1  serializer is not in TX_IDLE.
REQ-013 DONE  out  1  one-cycle pulse after the stop bit completes.

Function
REQ-014 FIFO write SHALL occur on any cycle with WR=1 and FULL=0; WR while FULL SHALL be dropped with no state change.
REQ-015 FIFO write SHALL be independent of TXEN.
REQ-016 On a simultaneous push and pop, occupancy SHALL be unchanged and both operations SHALL occur.
REQ-017 FULL and EMPTY SHALL be registered and SHALL reflect occupancy in the cycle after each push or pop.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Serializer states SHALL be one-hot: TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE.
REQ-020 TX_IDLE: if TXEN=1 and EMPTY=0, the FSM SHALL pop the head into a shift register, clear the baud counter and bit index, and go to TX_START.
REQ-021 TX_START SHALL drive TXD=0 for exactly BAUD_COUNT cycles.
REQ-022 TX_DATA SHALL drive DATA_WIDTH bits LSB first, each for exactly BAUD_COUNT cycles.
REQ-023 TX_STOP SHALL drive TXD=1 for BAUD_COUNT cycles.
REQ-024 TX_DONE SHALL last one cycle with TXD=1 and DONE=1, then go to TX_IDLE.
REQ-025 TXD SHALL be driven from a register, glitch-free.
REQ-026 Latency: TXD SHALL fall in the cycle after the pop.
REQ-027 Frame length, pop to DONE, SHALL be (DATA_WIDTH+2)*BAUD_COUNT+1 cycles.
REQ-028 Back-to-back frames SHALL be separated by exactly 2 cycles of TXD=1 beyond the stop bit (TX_DONE, then TX_IDLE pop).
REQ-029 The baud counter SHALL be $clog2(BAUD_COUNT) bits, SHALL count 0..BAUD_COUNT-1, and SHALL reset to 0 at each bit boundary.
REQ-030 The bit index SHALL be $clog2(DATA_WIDTH)+1 bits.
REQ-031 TXEN=0 mid-frame SHALL hold the state, counter, index and TXD unchanged and SHALL suppress pops; transmission SHALL resume seamlessly when TXEN returns to 1.
REQ-032 DATA changes after the pop SHALL NOT affect the frame in flight.

Reset
REQ-033 RESET SHALL force TX_IDLE, TXD=1, BUSY=0, DONE=0, EMPTY=1, FULL=0, pointers=0, counter=0, index=0 and shift register=0.
REQ-034 RESET mid-frame SHALL abort the frame immediately, return TXD high, and discard FIFO contents.
REQ-035 Outputs SHALL be valid from the first edge after RESET deasserts.

Structure
REQ-036 Shared package uart_pkg SHALL hold the default BAUD_COUNT and DATA_WIDTH and the one-hot state constants shared with the receiver.
REQ-037 The FIFO SHALL be a separate sub-module, uart_tx_fifo (parameters DATA_WIDTH and FIFO_DEPTH), instantiated once.

Verification
REQ-038 Single char, BAUD_COUNT=16: write 0xA5 with TXEN=1 -> TXD reads 0,1,0,1,0,0,1,0,1,1, each 16 cycles; DONE pulses once at cycle 161 after the pop.
REQ-039 Burst: write 0x00, 0xFF, 0x55 back-to-back -> three correct frames, each gap exactly 2 cycles; EMPTY=1 after the third pop.
REQ-040 Overflow, DEPTH=4, TXEN=0: write 6 chars -> FULL=1 after the 4th; chars 5 and 6 dropped; TXEN=1 -> exactly 4 frames sent.
REQ-041 Pause: drop TXEN for 50 cycles during bit 3 -> that bit lasts BAUD_COUNT+50 cycles and all other bits are unaffected.
REQ-042 Reset mid-frame: assert RESET during bit 5 -> TXD=1 and EMPTY=1 immediately; no DONE pulse.
REQ-043 Full boundary: WR with FULL=1 in the same cycle as a pop -> write dropped and occupancy drops by one.
